// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// the bubble instruction pattern and the default reset fetch address.
package fetch_stage_pkg;

    // Fetch controller states.
    //   ST_FETCH : a request for PCF is outstanding
    //   ST_HOLD  : an instruction is parked in the buffer while decode stalls
    //   ST_DRAIN : a stale request is still in flight after a redirect
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Instruction word presented to decode for a bubble.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_adder.sv
// Plain N-bit adder used for the PC+4 computation; the carry out is dropped
// so the sum wraps modulo 2^N.
module fetch_stage_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule : fetch_stage_adder

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Tracks PCF, issues single-outstanding requests to instruction memory,
// parks a fetched instruction while decode stalls, and drops the response of a
// request made obsolete by a decode redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallD,
    input  logic                     i_FlushD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemAck,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRData,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD,
    output logic                     o_FetchBusyF
);

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(32'd4);
    localparam logic [INSTR_WIDTH-1:0]   BUBBLE    = INSTR_WIDTH'(NOP);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ~(ADDRESS_WIDTH'(32'd3));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e               state_q,  state_d;
    logic [ADDRESS_WIDTH-1:0]   pcf_q,    pcf_d;
    logic [INSTR_WIDTH-1:0]     buf_q,    buf_d;
    logic [ADDRESS_WIDTH-1:0]   target_q, target_d;
    logic [INSTR_WIDTH-1:0]     instr_q,  instr_d;
    logic [ADDRESS_WIDTH-1:0]   pcplus4_q, pcplus4_d;
    logic                       valid_q,  valid_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                       redir_s;
    logic [ADDRESS_WIDTH-1:0]   redir_target_s;
    logic [ADDRESS_WIDTH-1:0]   pcf_plus4_s;
    logic                       avail_s;
    logic [INSTR_WIDTH-1:0]     avail_instr_s;

    // A redirect only takes effect when decode is not stalled; a stalled
    // decode may be holding a branch whose operands are not yet final.
    assign redir_s        = i_PCSrcD & ~i_StallD;
    assign redir_target_s = i_PCNextD & ALIGN_MSK;

    fetch_stage_adder #(
        .N (ADDRESS_WIDTH)
    ) u_pc_adder (
        .a_i   (pcf_q),
        .b_i   (PC_STEP),
        .sum_o (pcf_plus4_s)
    );

    // Instruction availability this cycle: a live ack while fetching, or the
    // parked buffer while holding. A DRAIN ack is stale and never counts.
    always_comb begin
        avail_s       = 1'b0;
        avail_instr_s = i_IMemRData;
        case (state_q)
            ST_FETCH: begin
                avail_s       = i_IMemAck;
                avail_instr_s = i_IMemRData;
            end
            ST_HOLD: begin
                avail_s       = 1'b1;
                avail_instr_s = buf_q;
            end
            ST_DRAIN: begin
                avail_s       = 1'b0;
                avail_instr_s = i_IMemRData;
            end
            default: begin
                avail_s       = 1'b0;
                avail_instr_s = i_IMemRData;
            end
        endcase
    end

    // Next-state, PC, buffer and latched-target logic of the fetch controller.
    always_comb begin
        state_d  = state_q;
        pcf_d    = pcf_q;
        buf_d    = buf_q;
        target_d = target_q;
        case (state_q)
            ST_FETCH: begin
                if (redir_s) begin
                    if (i_IMemAck) begin
                        // Response for the old path arrives with the redirect:
                        // drop it and fetch the target next.
                        pcf_d   = redir_target_s;
                        state_d = ST_FETCH;
                    end else begin
                        // Old request still in flight: remember where to go.
                        target_d = redir_target_s;
                        state_d  = ST_DRAIN;
                    end
                end else if (i_IMemAck) begin
                    if (i_StallD) begin
                        buf_d   = i_IMemRData;
                        state_d = ST_HOLD;
                    end else begin
                        pcf_d   = pcf_plus4_s;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redir_s) begin
                    pcf_d   = redir_target_s;
                    state_d = ST_FETCH;
                end else if (!i_StallD) begin
                    pcf_d   = pcf_plus4_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                // A later redirect supersedes the one already latched.
                if (redir_s) begin
                    target_d = redir_target_s;
                end else begin
                    target_d = target_q;
                end
                if (i_IMemAck) begin
                    pcf_d   = target_d;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // IF/ID register next value: stall freezes it outright, otherwise flush,
    // redirect or an empty fetch inserts a bubble that keeps the old PC+4.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (!i_StallD) begin
            if (i_FlushD || redir_s || !avail_s) begin
                instr_d   = BUBBLE;
                pcplus4_d = pcplus4_q;
                valid_d   = 1'b0;
            end else begin
                instr_d   = avail_instr_s;
                pcplus4_d = pcf_plus4_s;
                valid_d   = 1'b1;
            end
        end else begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end
    end

    // Controller state register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= ST_FETCH;
            pcf_q    <= RESET_PC;
            buf_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            buf_q    <= buf_d;
            target_q <= target_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            instr_q   <= BUBBLE;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The address is the PC register itself, so it cannot move while a
    // request waits for its ack.
    assign o_IMemReq    = (state_q != ST_HOLD);
    assign o_IMemAddr   = pcf_q;
    assign o_FetchBusyF = ~avail_s;
    assign o_InstrD     = instr_q;
    assign o_PCPlus4D   = pcplus4_q;
    assign o_ValidD     = valid_q;

endmodule : fetch_stage

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters: ADDRESS_WIDTH, 32, PC/address width; INSTR_WIDTH, 32, instruction width; RESET_PC, 32'h0000_0000, first fetch address.
REQ-002 Clocking SHALL use one clock and an asynchronous, active-high reset: i_CLK and i_RST.
REQ-003 i_CLK  in  1  clock; all state updates on its rising edge.
REQ-004 i_RST  in  1  asynchronous active-high reset.
REQ-005 i_StallD  in  1  hazard-unit stall; holds the PC and the IF/ID register.
REQ-006 i_FlushD  in  1  hazard-unit flush; IF/ID loads a bubble.
REQ-007 i_PCSrcD  in  1  decode redirect request (branch/jump taken).
REQ-008 i_PCNextD  in  ADDRESS_WIDTH  redirect target from decode.
REQ-009 o_IMemReq  out  1  instruction memory request.
REQ-010 o_IMemAddr  out  ADDRESS_WIDTH  request address, equal to PCF.
REQ-011 i_IMemAck  in  1  single-cycle response strobe; data valid with it.
REQ-012 i_IMemRData  in  INSTR_WIDTH  fetched instruction.
REQ-013 o_InstrD  out  INSTR_WIDTH  IF/ID instruction to decode.
REQ-014 o_PCPlus4D  out  ADDRESS_WIDTH  IF/ID PC+4 to decode.
REQ-015 o_ValidD  out  1  IF/ID holds a real instruction; 0 indicates a bubble.
REQ-016 o_FetchBusyF  out  1  high while no fetched instruction is available this cycle.

Function
REQ-017 FSM states: FETCH (request outstanding), HOLD (instruction buffered, decode stalled), DRAIN (stale request outstanding after redirect).
REQ-018 Effective redirect: redir = i_PCSrcD & ~i_StallD; i_PCSrcD is ignored while i_StallD=1.
REQ-019 The redirect target SHALL have bits [1:0] forced to 00 before use.
REQ-020 o_IMemReq=1 in FETCH and DRAIN, 0 in HOLD.
REQ-021 o_IMemAddr SHALL remain stable from request assertion until ack.
REQ-022 Available instruction: i_IMemAck in FETCH, or the buffer in HOLD.
REQ-023 o_FetchBusyF = ~available.
REQ-024 FETCH, ack, ~i_StallD, ~redir: IF/ID <= {i_IMemRData, PCF+4, valid=1}; PCF <= PCF+4; stay in FETCH.
REQ-025 FETCH, ack, i_StallD: data -> buffer; PCF unchanged; go to HOLD.
REQ-026 HOLD, ~i_StallD, ~redir: IF/ID <= buffer; PCF <= PCF+4; go to FETCH.
REQ-027 FETCH with redir and ack in the same cycle: discard data; PCF <= target; stay in FETCH.
REQ-028 FETCH with redir and no ack: latch target; go to DRAIN.
REQ-029 DRAIN: on ack, discard data; PCF <= latched target; go to FETCH. A new redir in DRAIN overwrites the latched target.
REQ-030 HOLD with redir: discard buffer; PCF <= target; go to FETCH.
REQ-031 IF/ID update when ~i_StallD, with priority: i_FlushD or redir or not available -> bubble (o_InstrD=0, o_ValidD=0, o_PCPlus4D unchanged); otherwise load.
REQ-032 i_StallD=1 SHALL hold IF/ID unchanged, even if i_FlushD=1.
REQ-033 PC arithmetic is modulo 2^ADDRESS_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
REQ-034 Fetch latency: with a zero-wait ack, one instruction enters IF/ID every cycle.

Reset
REQ-035 i_RST SHALL asynchronously set: state=FETCH, PCF=RESET_PC, buffer=0, target=0, o_InstrD=0, o_PCPlus4D=0, o_ValidD=0.
REQ-036 Reset mid-request: the outstanding ack is not tracked; the first post-reset ack belongs to RESET_PC. The memory side is reset by the same i_RST.
REQ-037 o_IMemReq SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-038 A shared package SHALL hold the state encodings (FETCH=0, HOLD=1, DRAIN=2, 2 bits), the NOP constant (32'h0), and the RESET_PC default.
REQ-039 The existing ADDER (N=ADDRESS_WIDTH) SHALL be instantiated for PCF+4; there SHALL be no other sub-module.

Verification
REQ-040 Reset, then ack every cycle with data 0x20080001, 0x20090002 -> o_ValidD=1 next cycles; o_PCPlus4D=0x4, then 0x8.
REQ-041 Ack at PCF=0x8 while i_StallD=1 for 3 cycles -> state=HOLD, o_IMemReq=0, IF/ID frozen; on release, buffered instr loads with o_PCPlus4D=0xC.
REQ-042 Redirect to 0x103 at PCF=0x10 with 2-cycle ack latency -> DRAIN; stale data is discarded and never reaches IF/ID; next o_IMemAddr=0x100.
REQ-043 i_PCSrcD=1 with i_StallD=1 -> ignored, PCF unchanged; i_FlushD=1 with ~i_StallD -> o_ValidD=0, o_InstrD=0.
REQ-044 PCF=0xFFFF_FFFC, ack -> o_PCPlus4D=0x0, next address 0x0; i_RST pulsed mid-DRAIN -> o_IMemAddr=RESET_PC and all outputs 0 immediately.
